event_reporter: RTL

EVENT_REPORTER -- requirements
Module: event_reporter

---
 rtl/event_reporter_pkg.sv | 27 ++
 rtl/sync_fifo.sv | 50 +++++
 rtl/event_reporter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/event_reporter_pkg.sv
// Event reporter shared definitions.
// Record layout, header constants and serializer states.
package event_reporter_pkg;

   localparam logic [3:0] HDR_NIBBLE = 4'hA;

   localparam logic [1:0] CLS_NONE = 2'b00;
   localparam logic [1:0] CLS_A    = 2'b01;
   localparam logic [1:0] CLS_B    = 2'b10;
   localparam logic [1:0] CLS_RSVD = 2'b11;

   localparam int UNIT_W  = 2;
   localparam int CLASS_W = 2;

   // Record is {unit, class, timestamp}.
   function automatic int rec_width(input int ts_w);
      return UNIT_W + CLASS_W + ts_w;
   endfunction

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HDR,
      ST_TS_HI,
      ST_TS_LO
   } ser_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data.
// Pointers carry one extra wrap bit to tell full from empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic             do_wr;
   logic             do_rd;

   assign empty_o   = (wr_ptr_q == rd_ptr_q);
   assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
   assign do_wr     = wr_en_i && !full_o;
   assign do_rd     = rd_en_i && !empty_o;

   // Storage array; contents are don't-care while empty.
   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
      end
   end

   // Read/write pointers; reset empties the FIFO.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/event_reporter.sv
// Spike event reporter: edge detect, per-unit pending slots,
// record FIFO and a 3-byte packet serializer.
module event_reporter
   import event_reporter_pkg::*;
#(
   parameter int NUM_UNITS  = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int TS_WIDTH   = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_UNITS-1:0]   spike_detection_array,
   input  logic [2*NUM_UNITS-1:0] event_out_array,
   output logic [7:0]             data_out,
   output logic                   data_valid,
   input  logic                   data_ready,
   output logic                   overflow
);

   localparam int REC_W = rec_width(TS_WIDTH);
   localparam int IDX_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

   logic [TS_WIDTH-1:0]  ts_q;
   logic [NUM_UNITS-1:0] spike_q;
   logic [NUM_UNITS-1:0] rise;

   logic [NUM_UNITS-1:0] pend_q,  pend_d;
   logic [CLASS_W-1:0]   cls_q [NUM_UNITS];
   logic [CLASS_W-1:0]   cls_d [NUM_UNITS];
   logic [TS_WIDTH-1:0]  sts_q [NUM_UNITS];
   logic [TS_WIDTH-1:0]  sts_d [NUM_UNITS];
   logic                 ovf_q, ovf_d;

   logic [IDX_W-1:0]     sel;
   logic                 sel_vld;
   logic                 wr_en;
   logic [REC_W-1:0]     wr_data;

   logic                 rd_en;
   logic [REC_W-1:0]     rd_data;
   logic                 full;
   logic                 empty;

   ser_state_e           state_q;
   logic [TS_WIDTH-1:0]  pkt_ts_q;
   logic [15:0]          pkt_ts16;
   logic [7:0]           hdr_byte;
   logic [7:0]           dout_q;
   logic                 dv_q;

   assign rise = spike_detection_array & ~spike_q;

   // Pick the lowest-indexed pending slot for this cycle's FIFO write.
   always_comb begin
      sel     = '0;
      sel_vld = 1'b0;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (pend_q[i] && !sel_vld) begin
            sel     = IDX_W'(i);
            sel_vld = 1'b1;
         end
      end
   end

   assign wr_en   = sel_vld && !full;
   assign wr_data = {UNIT_W'(sel), cls_q[sel], sts_q[sel]};

   // Slot update: a slot drained this cycle can take a new event.
   always_comb begin
      pend_d = pend_q;
      cls_d  = cls_q;
      sts_d  = sts_q;
      ovf_d  = ovf_q;
      for (int i = 0; i < NUM_UNITS; i++) begin
         if (wr_en && (sel == IDX_W'(i))) begin
            pend_d[i] = 1'b0;
         end
         if (rise[i]) begin
            if (!pend_d[i]) begin
               pend_d[i] = 1'b1;
               cls_d[i]  = event_out_array[2*i +: 2];
               sts_d[i]  = ts_q;
            end else begin
               ovf_d = 1'b1;
            end
         end
      end
   end

   // Timestamp, spike history, pending slots and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q    <= '0;
         spike_q <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
         for (int i = 0; i < NUM_UNITS; i++) begin
            cls_q[i] <= CLS_NONE;
            sts_q[i] <= '0;
         end
      end else begin
         ts_q    <= ts_q + 1'b1;
         spike_q <= spike_detection_array;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
         cls_q   <= cls_d;
         sts_q   <= sts_d;
      end
   end

   sync_fifo #(
      .WIDTH (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en),
      .wr_data_i (wr_data),
      .rd_en_i   (rd_en),
      .rd_data_o (rd_data),
      .full_o    (full),
      .empty_o   (empty)
   );

   assign rd_en = !empty &&
                  ((state_q == ST_IDLE) ||
                   ((state_q == ST_TS_LO) && data_ready));

   assign hdr_byte = {HDR_NIBBLE, rd_data[REC_W-1 -: 4]};
   assign pkt_ts16 = 16'(pkt_ts_q);

   // Serializer; the popped record's header loads with the pop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         pkt_ts_q <= '0;
         dout_q   <= 8'h00;
         dv_q     <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (rd_en) begin
                  pkt_ts_q <= rd_data[TS_WIDTH-1:0];
                  dout_q   <= hdr_byte;
                  dv_q     <= 1'b1;
                  state_q  <= ST_HDR;
               end
            end
            ST_HDR: begin
               if (data_ready) begin
                  dout_q  <= pkt_ts16[15:8];
                  state_q <= ST_TS_HI;
               end
            end
            ST_TS_HI: begin
               if (data_ready) begin
                  dout_q  <= pkt_ts16[7:0];
                  state_q <= ST_TS_LO;
               end
            end
            ST_TS_LO: begin
               if (data_ready) begin
                  if (rd_en) begin
                     pkt_ts_q <= rd_data[TS_WIDTH-1:0];
                     dout_q   <= hdr_byte;
                     state_q  <= ST_HDR;
                  end else begin
                     dout_q  <= 8'h00;
                     dv_q    <= 1'b0;
                     state_q <= ST_IDLE;
                  end
               end
            end
            default: begin
               dout_q  <= 8'h00;
               dv_q    <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign data_out   = dout_q;
   assign data_valid = dv_q;
   assign overflow   = ovf_q;

endmodule
